// File: rtl/two_phase_clock_gen_pkg.sv
// Shared types and constants for the two-phase clock generator.
// The state encoding and MODE values are used by the top-level FSM.
package two_phase_clock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_G12,
    S_P2,
    S_G21
  } state_t;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STOP = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

endpackage

// File: rtl/two_phase_clock_gen_phase_timer.sv
// Loadable down-counter with a zero flag.
// It times every phase and every gap of the clock generator.
module phase_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic [DIV_W-1:0] count,
  output logic             zero
);

  // The counter stops at zero and waits there until the next load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - DIV_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/two_phase_clock_gen.sv
// Two-phase non-overlapping clock generator with run, stop and single-step modes.
// Every output is registered from the next-state value, so no input reaches an output combinationally.
module two_phase_clock_gen
  import two_phase_clock_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int DEAD_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        MODE,
  input  logic              STEP,
  input  logic [DIV_W-1:0]  DIV,
  input  logic [DEAD_W-1:0] DEAD,
  output logic              PHI1,
  output logic              PHI2,
  output logic              PHI1_START,
  output logic              PHI2_END,
  output logic              IDLE
);

  state_t              st, nxt;
  logic [DIV_W-1:0]    div_q;
  logic [DEAD_W-1:0]   dead_q;
  logic [DEAD_W-1:0]   dead_dec;
  logic [DIV_W-1:0]    in_div_m1, div_m1, dead_m1;
  logic [DIV_W-1:0]    load_val, count;
  logic                load, zero, start, end_cycle, nxt_zero;

  assign in_div_m1 = (DIV == '0) ? '0 : DIV - DIV_W'(1);
  assign div_m1    = (div_q == '0) ? '0 : div_q - DIV_W'(1);
  assign dead_dec  = dead_q - DEAD_W'(1);
  assign dead_m1   = DIV_W'(dead_dec);

  phase_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .zero     (zero)
  );

  // MODE is only consulted at cycle boundaries, so a mode change never cuts a phase short.
  always_comb begin
    nxt       = st;
    load      = 1'b0;
    load_val  = '0;
    start     = 1'b0;
    end_cycle = 1'b0;
    case (st)
      S_IDLE: start = (MODE == MODE_RUN) || ((MODE == MODE_STEP) && STEP);
      S_P1: begin
        if (zero) begin
          load = 1'b1;
          if (dead_q != '0) begin
            nxt      = S_G12;
            load_val = dead_m1;
          end else begin
            nxt      = S_P2;
            load_val = div_m1;
          end
        end
      end
      S_G12: begin
        if (zero) begin
          nxt      = S_P2;
          load     = 1'b1;
          load_val = div_m1;
        end
      end
      S_P2: begin
        if (zero) begin
          if (dead_q != '0) begin
            nxt      = S_G21;
            load     = 1'b1;
            load_val = dead_m1;
          end else begin
            end_cycle = 1'b1;
          end
        end
      end
      S_G21:   end_cycle = zero;
      default: nxt = S_IDLE;
    endcase
    if (end_cycle) begin
      if (MODE == MODE_RUN) start = 1'b1;
      else                  nxt   = S_IDLE;
    end
    if (start) begin
      nxt      = S_P1;
      load     = 1'b1;
      load_val = in_div_m1;
    end
  end

  // PHI2_END looks ahead: it flags the P2 cycle in which the timer will read zero.
  assign nxt_zero = load ? (load_val == '0) : (count <= DIV_W'(1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st         <= S_IDLE;
      div_q      <= '0;
      dead_q     <= '0;
      PHI1       <= 1'b0;
      PHI2       <= 1'b0;
      PHI1_START <= 1'b0;
      PHI2_END   <= 1'b0;
      IDLE       <= 1'b1;
    end else begin
      st <= nxt;
      if (start) begin
        div_q  <= DIV;
        dead_q <= DEAD;
      end
      PHI1       <= (nxt == S_P1);
      PHI2       <= (nxt == S_P2);
      PHI1_START <= (nxt == S_P1) && (st != S_P1);
      PHI2_END   <= (nxt == S_P2) && nxt_zero;
      IDLE       <= (nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_two_phase_clock_gen.sv
// Directed scoreboard bench for two_phase_clock_gen.
// The stimulus process queues the expected outputs for each cycle, and a monitor compares them.
module tb_two_phase_clock_gen;
  import two_phase_clock_pkg::*;

  // Expected vector bit order: {PHI1, PHI2, PHI1_START, PHI2_END, IDLE}
  localparam logic [4:0] E_IDLE = 5'b00001;
  localparam logic [4:0] E_GAP  = 5'b00000;
  localparam logic [4:0] E_P1S  = 5'b10100;
  localparam logic [4:0] E_P1   = 5'b10000;
  localparam logic [4:0] E_P2   = 5'b01000;
  localparam logic [4:0] E_P2E  = 5'b01010;

  logic       clk = 1'b0;
  logic       rstN;
  logic [1:0] mode;
  logic       stepReq;
  logic [7:0] div;
  logic [3:0] dead;
  logic       phi1, phi2, phi1Start, phi2End, idle;

  logic [4:0] expQ[$];
  int         compared   = 0;
  int         mismatched = 0;

  two_phase_clock_gen #(.DIV_W(8), .DEAD_W(4)) dut (
    .CLK        (clk),
    .RST_N      (rstN),
    .MODE       (mode),
    .STEP       (stepReq),
    .DIV        (div),
    .DEAD       (dead),
    .PHI1       (phi1),
    .PHI2       (phi2),
    .PHI1_START (phi1Start),
    .PHI2_END   (phi2End),
    .IDLE       (idle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input logic [4:0] expVec);
    logic [4:0] got;
    got = {phi1, phi2, phi1Start, phi2End, idle};
    compared++;
    if (got !== expVec || (phi1 && phi2)) begin
      mismatched++;
      $display("[TB] FAIL outputs@%0d got {phi1,phi2,start,end,idle}=%b required %b",
               compared, got, expVec);
    end
  endtask

  // The monitor samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  // Inputs are already set by the caller; this queues the outputs expected after the next edge.
  task automatic applyStimulus(input logic [4:0] expVec);
    expQ.push_back(expVec);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runCycle(input int plen, input int gap);
    for (int i = 0; i < plen; i++) applyStimulus(i == 0 ? E_P1S : E_P1);
    for (int i = 0; i < gap; i++)  applyStimulus(E_GAP);
    for (int i = 0; i < plen; i++) applyStimulus(i == plen - 1 ? E_P2E : E_P2);
    for (int i = 0; i < gap; i++)  applyStimulus(E_GAP);
  endtask

  initial begin
    rstN = 1'b0; mode = MODE_RUN; stepReq = 1'b0; div = 8'd4; dead = 4'd1;
    applyStimulus(E_IDLE);
    applyStimulus(E_IDLE);

    // Free-run, DIV=4 DEAD=1: two full 10-cycle periods
    rstN = 1'b1;
    runCycle(4, 1);
    runCycle(4, 1);

    // DIV changed to 2 during P2: the current cycle keeps 4-cycle phases
    for (int i = 0; i < 4; i++) applyStimulus(i == 0 ? E_P1S : E_P1);
    applyStimulus(E_GAP);
    applyStimulus(E_P2);
    div = 8'd2;
    applyStimulus(E_P2);
    applyStimulus(E_P2);
    applyStimulus(E_P2E);
    applyStimulus(E_GAP);
    runCycle(2, 1);

    // DIV=0 DEAD=0: period of 2, a strobe on every phase cycle
    div = 8'd0; dead = 4'd0;
    runCycle(1, 0);
    runCycle(1, 0);
    runCycle(1, 0);

    // Stop requested during P1: the cycle finishes through G21
    div = 8'd3; dead = 4'd2;
    applyStimulus(E_P1S);
    mode = MODE_STOP;
    applyStimulus(E_P1);
    applyStimulus(E_P1);
    applyStimulus(E_GAP);
    applyStimulus(E_GAP);
    applyStimulus(E_P2);
    applyStimulus(E_P2);
    applyStimulus(E_P2E);
    applyStimulus(E_GAP);
    applyStimulus(E_GAP);
    applyStimulus(E_IDLE);
    applyStimulus(E_IDLE);

    // Single step: one cycle per pulse, and a STEP issued mid-cycle is ignored
    mode = MODE_STEP; div = 8'd2; dead = 4'd1;
    applyStimulus(E_IDLE);
    stepReq = 1'b1;
    applyStimulus(E_P1S);
    stepReq = 1'b0;
    applyStimulus(E_P1);
    applyStimulus(E_GAP);
    stepReq = 1'b1;
    applyStimulus(E_P2);
    stepReq = 1'b0;
    applyStimulus(E_P2E);
    applyStimulus(E_GAP);
    applyStimulus(E_IDLE);
    applyStimulus(E_IDLE);

    // STEP held high: back-to-back cycles separated by one idle cycle
    div = 8'd1; dead = 4'd0; stepReq = 1'b1;
    applyStimulus(E_P1S);
    applyStimulus(E_P2E);
    applyStimulus(E_IDLE);
    applyStimulus(E_P1S);
    applyStimulus(E_P2E);
    stepReq = 1'b0;
    applyStimulus(E_IDLE);
    applyStimulus(E_IDLE);

    // Reset during P2, then a clean restart
    mode = MODE_RUN; div = 8'd4; dead = 4'd1;
    for (int i = 0; i < 4; i++) applyStimulus(i == 0 ? E_P1S : E_P1);
    applyStimulus(E_GAP);
    applyStimulus(E_P2);
    rstN = 1'b0;
    applyStimulus(E_IDLE);
    applyStimulus(E_IDLE);
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(i == 0 ? E_P1S : E_P1);
    applyStimulus(E_GAP);
    applyStimulus(E_P2);
    applyStimulus(E_P2);
    applyStimulus(E_P2);
    applyStimulus(E_P2E);
    mode = MODE_STOP;
    applyStimulus(E_GAP);
    applyStimulus(E_IDLE);

    @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expected vectors left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/two_phase_clock_gen.md
# two_phase_clock_gen

Programmable two-phase clock generator for the 6502 core and its bus peripherals. From the single system clock it derives non-overlapping PHI1/PHI2 phases with runtime-selectable phase length and dead time. It also supports free-run, stop and single-step modes, and emits one-cycle phase strobes that downstream logic uses as clock enables. It sits between the board clock and the CPU/bus fabric.

## Interface
Parameters:
- DIV_W, 8, width of the phase-length field and counter
- DEAD_W, 4, width of the dead-time field

Ports (reset is synchronous, active-low):
- CLK  in  1  system clock; all logic on its rising edge
- RST_N  in  1  synchronous reset, active low
- MODE  in  2  00 free-run, 01 stop, 10 single-step, 11 treated as stop
- STEP  in  1  single-step request; level sampled each CLK
- DIV  in  DIV_W  phase length in CLK cycles; 0 is treated as 1
- DEAD  in  DEAD_W  non-overlap gap in CLK cycles; 0 means no gap
- PHI1  out  1  phase 1, registered
- PHI2  out  1  phase 2, registered
- PHI1_START  out  1  high for exactly the first CLK cycle in which PHI1 is high
- PHI2_END  out  1  high for exactly the last CLK cycle in which PHI2 is high
- IDLE  out  1  high while the generator is halted

## Operation
- FSM states: S_IDLE, S_P1, S_G12, S_P2, S_G21.
- Outputs per state: PHI1=1 only in S_P1; PHI2=1 only in S_P2. Both are 0 in all other states. IDLE=1 only in S_IDLE.
- Invariant: PHI1 and PHI2 are never high in the same cycle, for any input sequence.
- Cycle start: DIV and DEAD are latched on entry to S_P1 and held for the whole 6502 cycle. Input changes take effect only at the next S_P1 entry.
- Dwell times: S_P1 and S_P2 each last max(DIV,1) cycles. S_G12 and S_G21 each last DEAD cycles and are skipped entirely when DEAD=0.
- Timing: a single DIV_W-bit down-counter, loaded with length−1 on state entry. The state advances when the counter reaches 0. The counter is never loaded with a negative value.
- From S_G21, or from S_P2 when DEAD=0:
  - MODE=00 → S_P1 (next cycle starts).
  - Any other MODE → S_IDLE.
- From S_IDLE:
  - MODE=00 → S_P1.
  - MODE=10 with STEP=1 → S_P1; exactly one full cycle runs, then S_IDLE.
  - Otherwise remain in S_IDLE.
- STEP is ignored outside S_IDLE. Holding STEP high in step mode produces back-to-back single cycles, each passing through one S_IDLE cycle.
- A MODE change mid-cycle never truncates a phase. The current cycle always completes through S_G21.

## Timing
- Reset: while RST_N=0 at a CLK edge, state becomes S_IDLE and the counter clears. After that edge, PHI1=0, PHI2=0, PHI1_START=0, PHI2_END=0, IDLE=1.
- A reset asserted mid-phase forces these values at the next edge, with no partial-phase completion.
- Free-run start: first edge with RST_N=1 and MODE=00 enters S_P1. PHI1 and PHI1_START are high in the following cycle, giving 1-cycle latency.
- Period: 2·max(DIV,1) + 2·DEAD CLK cycles. Duty per phase: max(DIV,1)/period.
- Strobes: PHI1_START coincides with the first PHI1-high cycle. PHI2_END coincides with the last PHI2-high cycle. With DIV≤1 the single PHI2 cycle carries PHI2_END.
- All outputs are driven directly from flops, with no combinational path from inputs to outputs.

## Structure
- Package two_phase_clock_pkg holds:
  - the state enum (S_IDLE … S_G21);
  - the MODE constants MODE_RUN=2'b00, MODE_STOP=2'b01, MODE_STEP=2'b10.
- Natural sub-module: phase_timer, a loadable down-counter with a zero flag, parameterised by DIV_W. The FSM and output registers stay in the top module.

## Test plan
- Reset, then MODE=00, DIV=4, DEAD=1. Require:
  - period of 10 CLK;
  - PHI1 high 4, gap 1, PHI2 high 4, gap 1;
  - one PHI1_START and one PHI2_END per period;
  - no overlap.
- DIV=0, DEAD=0. Require PHI1 and PHI2 to alternate every CLK (period 2), with PHI1_START and PHI2_END high on every corresponding cycle.
- Change DIV from 4 to 2 while in S_P2. Require the current cycle to keep 4-cycle phases, and the next cycle to show 2-cycle phases.
- MODE=10, STEP pulsed 1 cycle while idle. Require exactly one PHI1 pulse and one PHI2 pulse, then IDLE=1. A STEP issued mid-cycle must produce no extra cycle.
- In free-run, switch MODE to 01 during S_P1. Require the cycle to finish through S_G21, then IDLE=1 with PHI1=PHI2=0.
- Assert RST_N=0 during S_P2. Require all outputs at reset values at the next edge, and a clean restart one cycle after release.
